// File: rtl/tpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tpu_ctrl_pkg
// Shared types and helpers for the systolic tile controller.
//   ctrl_state_t   : controller phase (IDLE, LOAD_W, STREAM, DRAIN)
//   ROW_W_DEFAULT  : default width of the row-count / input-address fields
//   drain_cycles() : cycles needed for the last partial sums to leave an
//                    N x N array after the final input row enters it
// -----------------------------------------------------------------------------
package tpu_ctrl_pkg;

    localparam int ROW_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } ctrl_state_t;

    // The last row needs N-1 cycles of skew plus N-1 column hops, plus one.
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// 1-bit shift register of depth D with a synchronous clear. Used to delay the
// row-0 valid/switch strobes by i cycles for array row i.
//   clk   in  rising-edge clock
//   clr_i in  synchronous clear of every stage (reset or abort)
//   d_i   in  undelayed bit
//   q_o   out d_i delayed by D cycles
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int D = 1
) (
    input  logic clk,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [D-1:0] sr_q;

    // NOTE: every stage is cleared, not just the head; a stale bit left in the
    // middle would otherwise surface as a spurious valid after an abort.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            sr_q <= '0;
        end else begin
            sr_q[0] <= d_i;
            for (int i = 1; i < D; i++) begin
                sr_q[i] <= sr_q[i-1];
            end
        end
    end

    assign q_o = sr_q[D-1];

endmodule

// File: rtl/systolic_tile_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_tile_ctrl
// Sequences one tile through an N x N systolic array: loads N weight rows from
// the north, switches them into the active registers together with the first
// input row, streams M input rows with a per-row diagonal skew, then waits
// 2N-1 cycles for the last partial sums to drain.
//   clk         in  rising-edge clock
//   rst         in  synchronous active-low reset
//   start       in  run one tile (sampled only in IDLE)
//   num_rows    in  M, captured when start is accepted
//   abort       in  return to IDLE on the next edge, no done pulse
//   busy        out high in every state except IDLE
//   done        out one-cycle pulse when a tile completes
//   pe_enable   out shared PE enable; high while busy
//   wt_rd_en    out weight buffer read strobe
//   wt_rd_addr  out weight row presented to the north edge
//   accept_w    out per-column weight accept for array row 0
//   in_rd_en    out input buffer read strobe
//   in_rd_addr  out input row index for west-edge row 0
//   row_valid   out per-row valid, row i delayed i cycles from row 0
//   row_switch  out per-row weight switch, skewed like row_valid
// -----------------------------------------------------------------------------
module systolic_tile_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int ROW_W = ROW_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ROW_W-1:0]     num_rows,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 pe_enable,
    output logic                 wt_rd_en,
    output logic [$clog2(N)-1:0] wt_rd_addr,
    output logic [N-1:0]         accept_w,
    output logic                 in_rd_en,
    output logic [ROW_W-1:0]     in_rd_addr,
    output logic [N-1:0]         row_valid,
    output logic [N-1:0]         row_switch
);

    localparam int AW = $clog2(N);
    localparam int DW = $clog2(2 * N);
    localparam logic [AW-1:0] K_LAST     = AW'(N - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(drain_cycles(N) - 1);

    ctrl_state_t      state_q, state_d;
    logic [AW-1:0]    k_q, k_d;          // weight row counter in LOAD_W
    logic [ROW_W-1:0] r_q, r_d;          // input row counter in STREAM
    logic [ROW_W-1:0] m_q, m_d;          // captured row count
    logic [DW-1:0]    drain_q, drain_d;  // down-counter in DRAIN

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wt_rd_en_q, wt_rd_en_d;
    logic [AW-1:0]    wt_rd_addr_q, wt_rd_addr_d;
    logic [N-1:0]     accept_w_q, accept_w_d;
    logic             in_rd_en_q, in_rd_en_d;
    logic [ROW_W-1:0] in_rd_addr_q, in_rd_addr_d;

    // ---------------------------------------------------------------- next state
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        m_d     = m_q;
        drain_d = drain_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (num_rows != '0) begin
                        m_d     = num_rows;
                        k_d     = '0;
                        state_d = LOAD_W;
                    end else begin
                        // Empty tile: nothing to run, complete immediately.
                        done_d = 1'b1;
                    end
                end
            end
            LOAD_W: begin
                if (k_q == K_LAST) begin
                    r_d     = '0;
                    state_d = STREAM;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            STREAM: begin
                if (r_q == m_q - 1'b1) begin
                    drain_d = DRAIN_LAST;
                    state_d = DRAIN;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d = IDLE;
            k_d     = '0;
            r_d     = '0;
            drain_d = '0;
            done_d  = 1'b0;
        end

        // Outputs are a function of the next state so they appear registered
        // in the same cycle the state does.
        busy_d       = (state_d != IDLE);
        wt_rd_en_d   = (state_d == LOAD_W);
        accept_w_d   = {N{wt_rd_en_d}};
        // Reverse order: the last row loaded settles in array row 0.
        wt_rd_addr_d = wt_rd_en_d ? K_LAST - k_d : '0;
        in_rd_en_d   = (state_d == STREAM);
        in_rd_addr_d = in_rd_en_d ? r_d : '0;
    end

    // ---------------------------------------------------------------- registers
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            r_q          <= '0;
            m_q          <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wt_rd_en_q   <= 1'b0;
            wt_rd_addr_q <= '0;
            accept_w_q   <= '0;
            in_rd_en_q   <= 1'b0;
            in_rd_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            r_q          <= r_d;
            m_q          <= m_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wt_rd_en_q   <= wt_rd_en_d;
            wt_rd_addr_q <= wt_rd_addr_d;
            accept_w_q   <= accept_w_d;
            in_rd_en_q   <= in_rd_en_d;
            in_rd_addr_q <= in_rd_addr_d;
        end
    end

    assign busy       = busy_q;
    assign pe_enable  = busy_q;
    assign done       = done_q;
    assign wt_rd_en   = wt_rd_en_q;
    assign wt_rd_addr = wt_rd_addr_q;
    assign accept_w   = accept_w_q;
    assign in_rd_en   = in_rd_en_q;
    assign in_rd_addr = in_rd_addr_q;

    // ---------------------------------------------------------------- skew
    // Row 0 is driven straight from state: the PE copies its weights
    // combinationally, so switch and the first input share one cycle.
    logic valid0, switch0, skew_clr;

    assign valid0        = (state_q == STREAM);
    assign switch0       = (state_q == STREAM) && (r_q == '0);
    assign skew_clr      = !rst || abort;
    assign row_valid[0]  = valid0;
    assign row_switch[0] = switch0;

    for (genvar i = 1; i < N; i++) begin : g_skew
        skew_delay_line #(.D(i)) u_valid (
            .clk   (clk),
            .clr_i (skew_clr),
            .d_i   (valid0),
            .q_o   (row_valid[i])
        );
        skew_delay_line #(.D(i)) u_switch (
            .clk   (clk),
            .clr_i (skew_clr),
            .d_i   (switch0),
            .q_o   (row_switch[i])
        );
    end

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_ctrl
// Directed bench for systolic_tile_ctrl with an N=2 and an N=4 instance.
// Cycle c is the clock period after edge c-1; start sampled at edge 0 makes
// cycle 1 the first LOAD_W cycle. Table entry c holds the outputs expected
// in cycle c and the inputs driven during cycle c.
// -----------------------------------------------------------------------------
module tb_systolic_tile_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N = 2 instance
    logic       rst2, start2, abort2;
    logic [7:0] num2;
    logic       busy2, done2, pe2, wten2, inen2;
    logic [0:0] wa2;
    logic [1:0] acc2, rv2, rs2;
    logic [7:0] ia2;

    // N = 4 instance
    logic       rst4, start4, abort4;
    logic [7:0] num4;
    logic       busy4, done4, pe4, wten4, inen4;
    logic [1:0] wa4;
    logic [3:0] acc4, rv4, rs4;
    logic [7:0] ia4;

    systolic_tile_ctrl #(.N(2), .ROW_W(8)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .num_rows(num2), .abort(abort2),
        .busy(busy2), .done(done2), .pe_enable(pe2), .wt_rd_en(wten2),
        .wt_rd_addr(wa2), .accept_w(acc2), .in_rd_en(inen2), .in_rd_addr(ia2),
        .row_valid(rv2), .row_switch(rs2)
    );

    systolic_tile_ctrl #(.N(4), .ROW_W(8)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .num_rows(num4), .abort(abort4),
        .busy(busy4), .done(done4), .pe_enable(pe4), .wt_rd_en(wten4),
        .wt_rd_addr(wa4), .accept_w(acc4), .in_rd_en(inen4), .in_rd_addr(ia4),
        .row_valid(rv4), .row_switch(rs4)
    );

    logic [19:0] obs2;
    logic [26:0] obs4;
    assign obs2 = {busy2, done2, pe2, wten2, wa2, acc2, inen2, ia2, rv2, rs2};
    assign obs4 = {busy4, done4, pe4, wten4, wa4, acc4, inen4, ia4, rv4, rs4};

    typedef struct packed {
        logic        start;
        logic [7:0]  num;
        logic        abort;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Expected N=2 output word; pe_enable must equal busy.
    function automatic logic [19:0] o2(input logic b, input logic d, input logic we,
                                       input logic wa, input logic [1:0] ac,
                                       input logic ie, input logic [7:0] ia,
                                       input logic [1:0] rv, input logic [1:0] rs);
        return {b, d, b, we, wa, ac, ie, ia, rv, rs};
    endfunction

    function automatic logic [19:0] ld(input logic wa);
        return o2(1'b1, 1'b0, 1'b1, wa, 2'b11, 1'b0, 8'd0, 2'b00, 2'b00);
    endfunction

    function automatic logic [19:0] st(input logic [7:0] ia, input logic [1:0] rv,
                                       input logic [1:0] rs);
        return o2(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, ia, rv, rs);
    endfunction

    function automatic logic [19:0] dr(input logic [1:0] rv, input logic [1:0] rs);
        return o2(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, rv, rs);
    endfunction

    function automatic logic [19:0] dn();
        return o2(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'd0, 2'b00, 2'b00);
    endfunction

    function automatic vec_t mk(input logic s, input logic [7:0] n, input logic a,
                                input logic [19:0] e);
        vec_t v;
        v.start = s;
        v.num   = n;
        v.abort = a;
        v.exp   = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [26:0] e4;
        logic [3:0]  sk;

        rst2 = 1'b0; start2 = 1'b0; num2 = 8'd0; abort2 = 1'b0;
        rst4 = 1'b0; start4 = 1'b0; num4 = 8'd0; abort4 = 1'b0;

        // N=2, M=3; start while busy (c2) and num_rows changes are ignored.
        tbl.push_back(mk(1'b1, 8'd3, 1'b0, 20'h0));               // c0
        tbl.push_back(mk(1'b0, 8'd7, 1'b0, ld(1'b1)));            // c1
        tbl.push_back(mk(1'b1, 8'd7, 1'b0, ld(1'b0)));            // c2
        tbl.push_back(mk(1'b0, 8'd7, 1'b0, st(8'd0, 2'b01, 2'b01)));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, st(8'd1, 2'b11, 2'b10)));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, st(8'd2, 2'b11, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, dr(2'b10, 2'b00)));    // c6
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, dr(2'b00, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, dr(2'b00, 2'b00)));    // c8
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, dn()));                // c9
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 20'h0));
        // Empty tile: done in c1 only, no strobes.
        tbl.push_back(mk(1'b1, 8'd0, 1'b0, 20'h0));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, dn()));
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 20'h0));
        // Abort in c4, restart in c6, done in c15.
        tbl.push_back(mk(1'b1, 8'd3, 1'b0, 20'h0));               // c0
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, ld(1'b1)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, ld(1'b0)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, st(8'd0, 2'b01, 2'b01)));
        tbl.push_back(mk(1'b0, 8'd0, 1'b1, st(8'd1, 2'b11, 2'b10))); // c4
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 20'h0));               // c5
        tbl.push_back(mk(1'b1, 8'd3, 1'b0, 20'h0));               // c6
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, ld(1'b1)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, ld(1'b0)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, st(8'd0, 2'b01, 2'b01)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, st(8'd1, 2'b11, 2'b10)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, st(8'd2, 2'b11, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, dr(2'b10, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, dr(2'b00, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, dr(2'b00, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, dn()));                // c15
        tbl.push_back(mk(1'b0, 8'd3, 1'b0, 20'h0));
        // Back-to-back, N=2, M=1: start held through the first done (c7).
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, 20'h0));               // c0
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, ld(1'b1)));
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, ld(1'b0)));
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, st(8'd0, 2'b01, 2'b01)));
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, dr(2'b10, 2'b10)));
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, dr(2'b00, 2'b00)));
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, dr(2'b00, 2'b00)));
        tbl.push_back(mk(1'b1, 8'd1, 1'b0, dn()));                // c7
        tbl.push_back(mk(1'b0, 8'd1, 1'b0, ld(1'b1)));            // c8
        tbl.push_back(mk(1'b0, 8'd1, 1'b0, ld(1'b0)));
        tbl.push_back(mk(1'b0, 8'd1, 1'b0, st(8'd0, 2'b01, 2'b01)));
        tbl.push_back(mk(1'b0, 8'd1, 1'b0, dr(2'b10, 2'b10)));
        tbl.push_back(mk(1'b0, 8'd1, 1'b0, dr(2'b00, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd1, 1'b0, dr(2'b00, 2'b00)));
        tbl.push_back(mk(1'b0, 8'd1, 1'b0, dn()));                // c14
        tbl.push_back(mk(1'b0, 8'd0, 1'b0, 20'h0));

        repeat (3) tick();
        rst2 = 1'b1;
        rst4 = 1'b1;
        tick();
        check("reset_n4", 32'(obs4), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("vec%0d", i), 32'(obs2), 32'(tbl[i].exp));
            start2 = tbl[i].start;
            num2   = tbl[i].num;
            abort2 = tbl[i].abort;
            tick();
        end

        // Reset asserted during STREAM (cycle 4): outputs clear, no done later.
        start2 = 1'b1;
        num2   = 8'd3;
        tick();
        start2 = 1'b0;
        repeat (3) tick();
        check("rst_pre_stream", 32'({inen2, rv2}), 32'({1'b1, 2'b11}));
        rst2 = 1'b0;
        tick();
        check("rst_clear", 32'(obs2), 32'h0);
        rst2 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rst_after%0d", c), 32'(obs2), 32'h0);
        end

        // N=4, M=1: skewed switch across rows, done in cycle 13.
        start4 = 1'b1;
        num4   = 8'd1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            sk = (c >= 5 && c <= 8) ? 4'(1 << (c - 5)) : 4'b0000;
            e4 = {(c <= 12) ? 1'b1 : 1'b0,
                  (c == 13) ? 1'b1 : 1'b0,
                  (c <= 12) ? 1'b1 : 1'b0,
                  (c <= 4)  ? 1'b1 : 1'b0,
                  (c <= 4)  ? 2'(4 - c) : 2'd0,
                  (c <= 4)  ? 4'hF : 4'h0,
                  (c == 5)  ? 1'b1 : 1'b0,
                  8'd0, sk, sk};
            check($sformatf("n4_c%0d", c), 32'(obs4), 32'(e4));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
